// File: rtl/pc_register_unit_if.sv
// Fetch-side bundle between the PC register and its neighbours (PC adder, branch/jump
// resolution, hazard unit and decode).
interface pc_register_unit_if #(
  parameter int COUNT_W = 16
);
  logic [31:0]        PCAddResult;
  logic               BranchTaken;
  logic [31:0]        BranchTarget;
  logic               Jump;
  logic [31:0]        JumpTarget;
  logic               Stall;
  logic               FetchReady;
  logic [31:0]        PCResult;
  logic               FetchValid;
  logic               Misaligned;
  logic [COUNT_W-1:0] FetchCount;

  modport master (
    output PCAddResult, BranchTaken, BranchTarget, Jump, JumpTarget, Stall, FetchReady,
    input  PCResult, FetchValid, Misaligned, FetchCount
  );

  modport slave (
    input  PCAddResult, BranchTaken, BranchTarget, Jump, JumpTarget, Stall, FetchReady,
    output PCResult, FetchValid, Misaligned, FetchCount
  );
endinterface

// File: rtl/pc_register_unit.sv
// Program counter register with BOOT/RUN/HALT sequencing, redirect priority,
// sticky misalignment trap and a wrapping accepted-fetch counter.
module pc_register_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          COUNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_register_unit_if.slave bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               mis_q, mis_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic        redirect;
  logic        accept;
  logic [31:0] target;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mis_d    = mis_q;
    count_d  = count_q;
    redirect = bus.Jump | bus.BranchTaken;
    accept   = bus.FetchReady & ~bus.Stall;
    target   = bus.PCAddResult;
    if (bus.Jump)             target = bus.JumpTarget;
    else if (bus.BranchTaken) target = bus.BranchTarget;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (accept) count_d = count_q + 1'b1;
        // A redirect flushes even while stalled; a bad target traps instead of loading.
        if (redirect || accept) begin
          if (target[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = target;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      count_q <= count_d;
    end
  end

  assign bus.PCResult   = pc_q;
  assign bus.FetchValid = (state_q == RUN);
  assign bus.Misaligned = mis_q;
  assign bus.FetchCount = count_q;
endmodule
